regfile_debug_port: RTL and testbench

- Debug initiator for the NBBPU 16 x 16-bit register file. It drives the regfile's read-address and write ports from a byte-wide command stream (host/UART side).
- Supports single-register read, single-register write, and a full 16-register dump.
- Responses return on a byte-wide valid/ready stream.
- Sits between the debug byte link and the regfile's second access path; `busy` lets the core stall while the port owns the regfile.

---
 rtl/regfile_debug_port.sv | 130 +++++++++++++
 tb/tb_regfile_debug_port.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_port.sv
// Debug initiator for the 16 x 16-bit register file: decodes byte commands from the
// debug link into single reads, single writes and a full register dump.
module regfile_debug_port #(
  parameter logic [7:0] ACK_BYTE = 8'hAA,
  parameter logic [7:0] ERR_BYTE = 8'hEE,
  parameter int         NUM_REGS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic [3:0]  reg_address_read,
  input  logic [15:0] reg_read_data,
  output logic        reg_write_enable,
  output logic [3:0]  reg_address_write,
  output logic [15:0] reg_write_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, GET_HI, GET_LO, WRITE, LATCH, SEND_HI, SEND_LO, SEND_ACK, SEND_ERR
  } state_t;

  localparam logic [3:0] LAST_REG = 4'(NUM_REGS - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] shadow;
  logic [3:0]  counter;
  logic        dump_mode;
  logic        rx_fire;
  logic        tx_fire;
  logic [3:0]  opcode;
  logic [3:0]  reg_index;

  assign opcode    = rx_data[7:4];
  assign reg_index = rx_data[3:0];
  assign rx_ready  = (state == IDLE) || (state == GET_HI) || (state == GET_LO);
  assign tx_valid  = (state == SEND_HI) || (state == SEND_LO) ||
                     (state == SEND_ACK) || (state == SEND_ERR);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign busy      = (state != IDLE);
  assign reg_write_enable = (state == WRITE);

  always_comb begin
    tx_data = 8'h00;
    case (state)
      SEND_HI:  tx_data = shadow[15:8];
      SEND_LO:  tx_data = shadow[7:0];
      SEND_ACK: tx_data = ACK_BYTE;
      SEND_ERR: tx_data = ERR_BYTE;
      default:  tx_data = 8'h00;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rx_fire) begin
          if (opcode == 4'h1)                            next_state = LATCH;
          else if (opcode == 4'h2)                       next_state = GET_HI;
          else if (opcode == 4'h3 && reg_index == 4'h0)  next_state = LATCH;
          else                                           next_state = SEND_ERR;
        end
      end
      GET_HI:   if (rx_fire) next_state = GET_LO;
      GET_LO:   if (rx_fire) next_state = WRITE;
      WRITE:    next_state = SEND_ACK;
      LATCH:    next_state = SEND_HI;
      SEND_HI:  if (tx_fire) next_state = SEND_LO;
      SEND_LO: begin
        if (tx_fire) begin
          if (dump_mode && counter != LAST_REG) next_state = LATCH;
          else                                  next_state = IDLE;
        end
      end
      SEND_ACK: if (tx_fire) next_state = IDLE;
      SEND_ERR: if (tx_fire) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The shadow snapshot keeps both response bytes from one regfile read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      shadow            <= 16'h0000;
      counter           <= 4'h0;
      dump_mode         <= 1'b0;
      reg_address_read  <= 4'h0;
      reg_address_write <= 4'h0;
      reg_write_data    <= 16'h0000;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (rx_fire) begin
            if (opcode == 4'h1) begin
              reg_address_read <= reg_index;
              dump_mode        <= 1'b0;
            end else if (opcode == 4'h2) begin
              reg_address_write <= reg_index;
            end else if (opcode == 4'h3 && reg_index == 4'h0) begin
              counter          <= 4'h0;
              reg_address_read <= 4'h0;
              dump_mode        <= 1'b1;
            end
          end
        end
        GET_HI: if (rx_fire) reg_write_data[15:8] <= rx_data;
        GET_LO: if (rx_fire) reg_write_data[7:0]  <= rx_data;
        LATCH:  shadow <= reg_read_data;
        SEND_LO: begin
          if (tx_fire && dump_mode && counter != LAST_REG) begin
            counter          <= counter + 4'd1;
            reg_address_read <= counter + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Self-checking bench for regfile_debug_port: a behavioural regfile on the far side,
// a table of command vectors, latency/stall/reset sequences and randomized traffic.
module tb_regfile_debug_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic [3:0]  reg_address_read;
  logic [15:0] reg_read_data;
  logic        reg_write_enable;
  logic [3:0]  reg_address_write;
  logic [15:0] reg_write_data;
  logic        busy;

  regfile_debug_port dut (
    .clock(clock), .reset(reset),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .reg_address_read(reg_address_read), .reg_read_data(reg_read_data),
    .reg_write_enable(reg_write_enable), .reg_address_write(reg_address_write),
    .reg_write_data(reg_write_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Environment regfile; the core-side preload port models the other write path.
  logic [15:0] rf [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = 4'h0;
  logic [15:0] pre_data = 16'h0;
  assign reg_read_data = (reg_address_read == 4'd0) ? 16'h0000 : rf[reg_address_read];
  always @(posedge clock) begin
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (reg_write_enable) rf[reg_address_write] <= reg_write_data;
  end

  // Expected register contents, updated from the command rules alone.
  logic [15:0] exp_regs [16];
  int total = 0;
  int bad = 0;
  int ready_mode = 0;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // tx_ready changes just after each rising edge: always 1, toggling, or random.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic [7:0]  tx_q [$];
  int          wr_count = 0;
  logic [3:0]  wr_addr_log = 4'h0;
  logic [15:0] wr_data_log = 16'h0;
  logic        stall_pending = 1'b0;
  logic [7:0]  held_data = 8'h00;

  // Transfers, write strobes and stall stability are observed mid-cycle.
  always @(negedge clock) begin
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (reg_write_enable) begin
        wr_count++;
        wr_addr_log = reg_address_write;
        wr_data_log = reg_write_data;
      end
      if (stall_pending && tx_valid) check_output("stall_hold", {8'h00, tx_data}, {8'h00, held_data});
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      stall_pending = tx_valid && !tx_ready;
      held_data = tx_data;
    end
  end

  task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
    @(negedge clock);
    pre_en = 1'b1;
    pre_addr = r;
    pre_data = v;
    @(negedge clock);
    pre_en = 1'b0;
    exp_regs[r] = v;
  endtask

  // Returns just after the rising edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data = b;
    while (!rx_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (!rx_ready) begin
      note_timeout("rx_accept");
      rx_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_bytes_and_idle(input string name, input int n);
    int guard = 0;
    while (tx_q.size() < n && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (tx_q.size() < n) note_timeout(name);
    guard = 0;
    @(negedge clock);
    while (busy && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (busy) note_timeout(name);
  endtask

  task automatic apply_stimulus(input string name, input int ncmd, input logic [23:0] cmd,
                                input int nresp, input logic [15:0] resp, input int nwr);
    logic [7:0] act;
    logic [7:0] exp;
    tx_q.delete();
    wr_count = 0;
    for (int k = 0; k < ncmd; k++) send_byte(cmd[23 - 8*k -: 8]);
    wait_bytes_and_idle(name, nresp);
    for (int k = 0; k < nresp; k++) begin
      act = (k < tx_q.size()) ? tx_q[k] : 8'hxx;
      exp = resp[15 - 8*k -: 8];
      check_output($sformatf("%s_byte%0d", name, k), {8'h00, act}, {8'h00, exp});
    end
    check_output({name, "_count"}, 16'(tx_q.size()), 16'(nresp));
    check_output({name, "_writes"}, 16'(wr_count), 16'(nwr));
    if (ncmd == 3 && cmd[23:20] == 4'h2) begin
      exp_regs[cmd[19:16]] = cmd[15:0];
      check_output({name, "_waddr"}, {12'h0, wr_addr_log}, {12'h0, cmd[19:16]});
      check_output({name, "_wdata"}, wr_data_log, cmd[15:0]);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] r);
    return (r == 4'd0) ? 16'h0000 : exp_regs[r];
  endfunction

  typedef struct {
    string       name;
    int          ncmd;
    logic [23:0] cmd;
    int          nresp;
    logic [15:0] resp;
    int          nwr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles;
    int guard;
    logic [15:0] v;
    logic [3:0]  r;
    logic [7:0]  b;
    int          kind;

    vecs[0]  = '{"rd_r2",    1, 24'h120000, 2, 16'h000B, 0};
    vecs[1]  = '{"rd_r3",    1, 24'h130000, 2, 16'h001F, 0};
    vecs[2]  = '{"rd_r15",   1, 24'h1F0000, 2, 16'hBEEF, 0};
    vecs[3]  = '{"err_7a",   1, 24'h7A0000, 1, 16'hEE00, 0};
    vecs[4]  = '{"err_31",   1, 24'h310000, 1, 16'hEE00, 0};
    vecs[5]  = '{"err_05",   1, 24'h050000, 1, 16'hEE00, 0};
    vecs[6]  = '{"wr_r10",   3, 24'h2AC0DE, 1, 16'hAA00, 1};
    vecs[7]  = '{"rd_r10",   1, 24'h1A0000, 2, 16'hC0DE, 0};
    vecs[8]  = '{"wr_r0",    3, 24'h205566, 1, 16'hAA00, 1};
    vecs[9]  = '{"rd_r0",    1, 24'h100000, 2, 16'h0000, 0};
    vecs[10] = '{"err_3f",   1, 24'h3F0000, 1, 16'hEE00, 0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
    check_output("rst_busy", {15'h0, busy}, 16'h0);
    check_output("rst_we", {15'h0, reg_write_enable}, 16'h0);
    check_output("rst_raddr", {12'h0, reg_address_read}, 16'h0);
    check_output("rst_waddr", {12'h0, reg_address_write}, 16'h0);
    check_output("rst_wdata", reg_write_data, 16'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));
    set_reg(4'd2, 16'd11);
    set_reg(4'd3, 16'd31);
    set_reg(4'd15, 16'hBEEF);

    $display("[TB] read latency on r2");
    tx_q.delete();
    send_byte(8'h12);
    @(negedge clock);
    check_output("rd_lat_n1_valid", {15'h0, tx_valid}, 16'h0);
    check_output("rd_lat_n1_busy", {15'h0, busy}, 16'h1);
    @(negedge clock);
    check_output("rd_lat_n2_valid", {15'h0, tx_valid}, 16'h1);
    check_output("rd_lat_n2_data", {8'h0, tx_data}, 16'h0000);
    @(negedge clock);
    check_output("rd_lat_n3_valid", {15'h0, tx_valid}, 16'h1);
    check_output("rd_lat_n3_data", {8'h0, tx_data}, 16'h000B);
    @(negedge clock);
    check_output("rd_lat_n4_busy", {15'h0, busy}, 16'h0);

    $display("[TB] write latency to r5");
    wr_count = 0;
    send_byte(8'h25);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clock);
    check_output("wr_lat_we", {15'h0, reg_write_enable}, 16'h1);
    check_output("wr_lat_addr", {12'h0, reg_address_write}, 16'h5);
    check_output("wr_lat_data", reg_write_data, 16'h1234);
    @(negedge clock);
    check_output("wr_lat_we_off", {15'h0, reg_write_enable}, 16'h0);
    check_output("wr_lat_ack_valid", {15'h0, tx_valid}, 16'h1);
    check_output("wr_lat_ack_data", {8'h0, tx_data}, 16'h00AA);
    @(negedge clock);
    check_output("wr_lat_idle", {15'h0, busy}, 16'h0);
    check_output("wr_lat_strobes", 16'(wr_count), 16'd1);
    exp_regs[5] = 16'h1234;
    apply_stimulus("rd_r5", 1, 24'h150000, 2, 16'h1234, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++)
      apply_stimulus(vecs[i].name, vecs[i].ncmd, vecs[i].cmd, vecs[i].nresp, vecs[i].resp, vecs[i].nwr);

    $display("[TB] full dump");
    tx_q.delete();
    wr_count = 0;
    send_byte(8'h30);
    busy_cycles = 0;
    guard = 0;
    @(negedge clock);
    while (busy && guard < 200) begin
      busy_cycles++;
      guard++;
      @(negedge clock);
    end
    check_output("dump_cycles", 16'(busy_cycles), 16'd48);
    check_output("dump_count", 16'(tx_q.size()), 16'd32);
    for (int i = 0; i < 16; i++) begin
      v = model_read(4'(i));
      check_output($sformatf("dump_r%0d", i),
                   {(2*i < tx_q.size()) ? tx_q[2*i] : 8'hxx,
                    (2*i+1 < tx_q.size()) ? tx_q[2*i+1] : 8'hxx}, v);
    end
    if (tx_q.size() == 32) begin
      check_output("dump_r3_bytes", {tx_q[6], tx_q[7]}, 16'h001F);
      check_output("dump_last_bytes", {tx_q[30], tx_q[31]}, 16'hBEEF);
    end else begin
      note_timeout("dump_bytes");
    end
    check_output("dump_writes", 16'(wr_count), 16'd0);

    $display("[TB] read under toggling tx_ready");
    ready_mode = 1;
    apply_stimulus("rd_r2_stall", 1, 24'h120000, 2, 16'h000B, 0);
    ready_mode = 0;

    $display("[TB] reset mid-write");
    wr_count = 0;
    v = exp_regs[4];
    send_byte(8'h24);
    send_byte(8'h99);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_output("abort_busy", {15'h0, busy}, 16'h0);
    check_output("abort_writes", 16'(wr_count), 16'd0);
    apply_stimulus("abort_rd_r4", 1, 24'h140000, 2, v, 0);

    $display("[TB] randomized traffic");
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      r = 4'($urandom_range(0, 15));
      if (kind == 1) begin
        v = 16'($urandom);
        apply_stimulus($sformatf("rnd%0d_wr", i), 3, {4'h2, r, v}, 1, 16'hAA00, 1);
      end else if (kind == 2) begin
        b = 8'($urandom);
        while (b[7:4] == 4'h1 || b[7:4] == 4'h2 || b == 8'h30) b = 8'($urandom);
        apply_stimulus($sformatf("rnd%0d_err", i), 1, {b, 16'h0}, 1, 16'hEE00, 0);
      end else begin
        apply_stimulus($sformatf("rnd%0d_rd", i), 1, {4'h1, r, 16'h0}, 2, model_read(r), 0);
      end
    end
    ready_mode = 0;

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
